// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among N_REQ readers.
// Returns ROM data two cycles after each transfer, tagged one-hot by requester.
module sprite_rom_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic                    vga_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rvalid
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_rom_address;
  logic [N_REQ-1:0]  r_tag1;
  logic [N_REQ-1:0]  r_tag2;
  logic [N_REQ-1:0]  r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic [N_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]  w_next;
  logic [ADDR_W-1:0] w_addr;
  logic              w_found;
  logic              w_xfer;

  // Search starts at r_ptr and wraps; first requester found wins.
  always_comb begin
    w_grant = '0;
    w_next  = r_ptr;
    w_addr  = r_rom_address;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_found && req[j]) begin
        w_found    = 1'b1;
        w_grant[j] = 1'b1;
        w_addr     = addr[j*ADDR_W +: ADDR_W];
        w_next     = (j == N_REQ - 1) ? '0 : PTR_W'(j + 1);
      end
    end
    if (reset) w_grant = '0;
  end

  assign w_xfer = |(req & w_grant);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_ptr         <= '0;
      r_rom_address <= '0;
      r_tag1        <= '0;
      r_tag2        <= '0;
      r_rvalid      <= '0;
      r_rdata       <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr         <= w_next;
        r_rom_address <= w_addr;
        r_tag1        <= w_grant;
      end else begin
        r_tag1 <= '0;
      end
      r_tag2   <= r_tag1;
      r_rvalid <= r_tag2;
      if (|r_tag2) r_rdata <= rom_q;
    end
  end

  assign grant       = w_grant;
  assign rom_address = r_rom_address;
  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized bench for sprite_rom_arbiter against a queue-based model.
// ROM is modelled as a synchronous array driven by rom_address.
module tb_sprite_rom_arbiter;

  logic        vga_clk;
  logic        reset;
  logic [2:0]  req;
  logic [29:0] addr;
  logic [2:0]  grant;
  logic [9:0]  rom_address;
  logic [3:0]  rom_q;
  logic [3:0]  rdata;
  logic [2:0]  rvalid;

  sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(10), .DATA_W(4)) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .req        (req),
    .addr       (addr),
    .grant      (grant),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .rdata      (rdata),
    .rvalid     (rvalid)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [3:0] rom [1024];
  always @(posedge vga_clk) rom_q <= rom[rom_address];

  typedef struct {
    int         due;
    logic [2:0] tag;
    logic [3:0] data;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mptr = 0;
  logic [9:0] m_ra = '0;
  logic [3:0] m_rd = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] r);
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (mptr + k) % 3;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic step(input logic [2:0] r, input logic [9:0] a0,
                      input logic [9:0] a1, input logic [9:0] a2);
    int         w;
    logic [2:0] g;
    logic [9:0] av [3];
    logic [2:0] ev;
    av[0] = a0; av[1] = a1; av[2] = a2;
    @(negedge vga_clk);
    req  = r;
    addr = {a2, a1, a0};
    #1;
    w = pick(r);
    g = (w < 0) ? 3'b000 : 3'(1 << w);
    check("grant", 32'(grant), 32'(g));
    @(posedge vga_clk);
    #1;
    cyc++;
    if (w >= 0) begin
      exp_t e;
      e.due  = cyc + 2;
      e.tag  = g;
      e.data = rom[av[w]];
      q.push_back(e);
      m_ra = av[w];
      mptr = (w + 1) % 3;
    end
    ev = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev   = q[0].tag;
      m_rd = q[0].data;
      void'(q.pop_front());
    end
    check("rvalid", 32'(rvalid), 32'(ev));
    check("rdata", 32'(rdata), 32'(m_rd));
    check("rom_address", 32'(rom_address), 32'(m_ra));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom);
    rom[16] = 4'h5;
    reset = 1'b1;
    req   = 3'b111;
    addr  = '0;
    #12;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_addr", 32'(rom_address), 32'd0);
    @(negedge vga_clk);
    reset = 1'b0;
    req   = 3'b000;

    // Single read of ROM[0x010] = 5.
    step(3'b001, 10'h010, '0, '0);
    idle(3);
    check("single_rdata", 32'(rdata), 32'h5);

    // Full contention, then wrap behaviour.
    for (int i = 0; i < 6; i++)
      step(3'b111, 10'($urandom), 10'($urandom), 10'($urandom));
    idle(2);
    step(3'b100, '0, '0, 10'h3ff);
    step(3'b101, 10'h001, '0, 10'h002);
    step(3'b101, 10'h003, '0, 10'h004);
    idle(2);

    // Idle gap between transfers.
    step(3'b010, '0, 10'h123, '0);
    idle(3);
    step(3'b010, '0, 10'h321, '0);
    idle(3);

    // Reset while a read is in flight.
    step(3'b001, 10'h010, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_addr", 32'(rom_address), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge vga_clk);
      #1;
      check("inrst_rvalid", 32'(rvalid), 32'd0);
      check("inrst_rdata", 32'(rdata), 32'd0);
    end
    @(negedge vga_clk);
    reset = 1'b0;
    req   = 3'b000;
    q.delete();
    mptr = 0;
    m_ra = '0;
    m_rd = '0;
    step(3'b110, '0, 10'h055, 10'h066);
    check("post_rst_ptr", 32'(mptr), 32'd2);
    idle(3);

    // Single persistent requester, incrementing address.
    for (int i = 0; i < 5; i++) step(3'b100, '0, '0, 10'(i));
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(3'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    idle(3);
    check("drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
